// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder built from two halfadder cells,
// a carry flop and operand/sum shift registers. One addition at a time,
// with a start/busy/done handshake and a registered sum/cout result.

// Half-adder cell used to build the per-bit full-adder slice.
module halfadder (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);

   assign s = a ^ b;
   assign c = a & b;

endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   state_t           state_next;

   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-2:0] sum_sh;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic             ha0_s;
   logic             ha0_c;
   logic             sum_bit;
   logic             ha1_c;
   logic             carry_next;
   logic             last_bit;
   logic [WIDTH-1:0] sum_full;

   // First half adder combines the two operand LSBs.
   halfadder u_ha0 (
      .a (a_sh[0]),
      .b (b_sh[0]),
      .s (ha0_s),
      .c (ha0_c)
   );

   // Second half adder folds in the running carry to give this bit's sum.
   halfadder u_ha1 (
      .a (ha0_s),
      .b (carry),
      .s (sum_bit),
      .c (ha1_c)
   );

   // Both half-adder carries can never be high together, so OR gives the majority.
   assign carry_next = ha0_c | ha1_c;
   assign last_bit   = (cnt == CW'(WIDTH - 1));

   // sum_sh keeps the WIDTH-1 bits produced so far; with the current bit on top
   // it is the full result on the last bit, and its LSB simply drops off otherwise.
   assign sum_full   = {sum_bit, sum_sh};

   // State register, cleared to IDLE by the synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state: accept start only in IDLE, leave RUN after the last bit, DONE lasts one cycle.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (last_bit) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Handshake outputs depend only on the registered state.
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         RUN:     busy = 1'b1;
         DONE:    begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
            done = 1'b0;
         end
      endcase
   end

   // Datapath: capture operands on accept, shift one bit per RUN cycle, publish the result on the last bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh   <= '0;
         b_sh   <= '0;
         sum_sh <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         sum    <= '0;
         cout   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  carry <= cin;
                  cnt   <= '0;
               end
            end
            RUN: begin
               a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
               b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
               sum_sh <= sum_full[WIDTH-1:1];
               carry  <= carry_next;
               cnt    <= cnt + 1'b1;
               if (last_bit) begin
                  sum  <= sum_full;
                  cout <= carry_next;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
